// File: rtl/connect_four_pkg.sv
// Shared definitions for the connect-four input path.
// Contents:
//   - button index constants (which btn bit means what)
//   - repeat FSM state type
//   - default timing constants, derived from the 25 MHz pixel clock
//   - max_int helper, used to size counters
package connect_four_pkg;

  // Button channel indices within btn_raw / btn_pulse / btn_level.
  localparam int BTN_DROP  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_LEFT  = 2;
  localparam int NUM_BTN_DEF = 3;

  // Hold-to-repeat state per channel.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Timing defaults for a 25 MHz clock.
  localparam int CLK_HZ              = 25_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;  // 10 ms
  localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;    // 0.5 s
  localparam int REPEAT_RATE_DEF     = CLK_HZ / 8;    // 0.125 s

  // Left and right auto-scroll; drop never repeats.
  localparam logic [NUM_BTN_DEF-1:0] REPEAT_MASK_DEF = 3'b110;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce, rising-edge pulse and
// an optional hold-to-repeat FSM.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_raw    asynchronous raw button level
//   btn_pulse  registered one-cycle strobe (press and repeat events)
//   btn_level  debounced level
module button_channel
  import connect_four_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  // rcnt must hold the larger terminal value itself, hence the +1.
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RCNT_RATE  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] RCNT_ONE   = RW'(1);

  logic          s1_reg;
  logic          s2_reg;
  logic          stb_reg;
  logic [DW-1:0] dcnt_reg;
  logic          pulse_reg;

  rep_state_t    state_reg;
  rep_state_t    state_next;
  logic [RW-1:0] rcnt_reg;
  logic [RW-1:0] rcnt_next;
  logic          rep_fire;
  logic          stb_rise;

  // The edge on which stb is about to go 0->1.
  assign stb_rise = s2_reg && !stb_reg && (dcnt_reg == DCNT_LAST);

  // Synchroniser, debounce and output pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      stb_reg   <= 1'b0;
      dcnt_reg  <= '0;
      pulse_reg <= 1'b0;
    end else begin
      s1_reg <= btn_raw;
      s2_reg <= s1_reg;
      // Any return to the stable level restarts the count, so bounces
      // shorter than DEBOUNCE_CYCLES are discarded entirely.
      if (s2_reg != stb_reg) begin
        if (dcnt_reg == DCNT_LAST) begin
          stb_reg  <= s2_reg;
          dcnt_reg <= '0;
        end else begin
          dcnt_reg <= dcnt_reg + DW'(1);
        end
      end else begin
        dcnt_reg <= '0;
      end
      pulse_reg <= stb_rise | rep_fire;
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  // Repeat FSM next-state logic. rcnt counts from 1 so that a repeat lands
  // exactly REPEAT_DELAY (then REPEAT_RATE) edges after the previous pulse.
  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    rep_fire   = 1'b0;
    if (REPEAT_EN) begin
      case (state_reg)
        IDLE: begin
          if (stb_rise) begin
            state_next = DELAY;
            rcnt_next  = RCNT_ONE;
          end
        end
        DELAY: begin
          if (!stb_reg) begin
            state_next = IDLE;
            rcnt_next  = '0;
          end else if (rcnt_reg == RCNT_DELAY) begin
            rep_fire   = 1'b1;
            state_next = REPEAT;
            rcnt_next  = RCNT_ONE;
          end else begin
            rcnt_next = rcnt_reg + RCNT_ONE;
          end
        end
        REPEAT: begin
          if (!stb_reg) begin
            state_next = IDLE;
            rcnt_next  = '0;
          end else if (rcnt_reg == RCNT_RATE) begin
            rep_fire  = 1'b1;
            rcnt_next = RCNT_ONE;
          end else begin
            rcnt_next = rcnt_reg + RCNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          rcnt_next  = '0;
        end
      endcase
    end else begin
      state_next = IDLE;
      rcnt_next  = '0;
    end
  end

  assign btn_pulse = pulse_reg;
  assign btn_level = stb_reg;

endmodule

// File: rtl/button_conditioner.sv
// Input conditioning for the connect-four buttons (drop, right, left).
// Each channel is synchronised, debounced and edge-detected independently;
// channels selected by REPEAT_MASK also auto-repeat while held.
// Ports:
//   clk        system clock (25 MHz pixel clock)
//   rst        asynchronous active-high reset
//   btn_raw    raw button levels, active-high (bit0 drop, bit1 right, bit2 left)
//   btn_pulse  one-cycle move strobes to connect_four_top
//   btn_level  debounced button levels
module button_conditioner
  import connect_four_pkg::*;
#(
  parameter int                 NUM_BTN         = NUM_BTN_DEF,
  parameter int                 DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int                 REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int                 REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = REPEAT_MASK_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level
);

  // Channels are fully independent; simultaneous pulses are passed through
  // and left for the game FSM to arbitrate.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_MASK[gi])
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw[gi]),
        .btn_pulse(btn_pulse[gi]),
        .btn_level(btn_level[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing:
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
// Expected pulse events (edge number, value) are pushed to a scoreboard
// queue when stimulus is applied and popped when the DUT pulses.
module tb_button_conditioner;
  import connect_four_pkg::*;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic [2:0] btn_level;

  int edge_cnt = 0;
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int         edge_no;
    logic [2:0] pulse;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] exp_level;
    int         pulse_at;   // edges after vector start, 0 = none
    logic [2:0] pulse_val;
  } vec_t;
  vec_t vecs[10];

  button_conditioner #(
    .NUM_BTN        (3),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_MASK    (3'b110)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
  endtask

  function automatic void expect_pulse(input int e, input logic [2:0] v);
    exp_t x;
    x.edge_no = e;
    x.pulse   = v;
    sb.push_back(x);
  endfunction

  // Any nonzero pulse, or an expected event that is due, is a comparison.
  task automatic monitor();
    exp_t e;
    if (btn_pulse != 3'b000 || (sb.size() > 0 && sb[0].edge_no <= edge_cnt)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'(btn_pulse), 0);
      end else begin
        e = sb.pop_front();
        check("pulse_edge", edge_cnt, e.edge_no);
        check("pulse_val", int'(btn_pulse), int'(e.pulse));
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mon_en) monitor();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    rst     = 1'b1;
    btn_raw = 3'b000;

    // Clean press on drop, then a bounce on right that must leave no trace.
    vecs[0] = '{3'b001, 5,  3'b000, 6, 3'b001};
    vecs[1] = '{3'b001, 1,  3'b001, 0, 3'b000};
    vecs[2] = '{3'b001, 24, 3'b001, 0, 3'b000};
    vecs[3] = '{3'b000, 5,  3'b001, 0, 3'b000};
    vecs[4] = '{3'b000, 1,  3'b000, 0, 3'b000};
    vecs[5] = '{3'b010, 3,  3'b000, 0, 3'b000};
    vecs[6] = '{3'b000, 1,  3'b000, 0, 3'b000};
    vecs[7] = '{3'b010, 3,  3'b000, 0, 3'b000};
    vecs[8] = '{3'b000, 1,  3'b000, 0, 3'b000};
    vecs[9] = '{3'b000, 8,  3'b000, 0, 3'b000};

    tick(3);
    check("reset_level", int'(btn_level), 0);
    check("reset_pulse", int'(btn_pulse), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      base    = edge_cnt;
      btn_raw = vecs[i].raw;
      if (vecs[i].pulse_at > 0) expect_pulse(base + vecs[i].pulse_at, vecs[i].pulse_val);
      tick(vecs[i].hold);
      check($sformatf("vec%0d_level", i), int'(btn_level), int'(vecs[i].exp_level));
    end
    tick(10);

    // Auto-repeat on left: held 40 cycles; stb falls at edge 46.
    base    = edge_cnt;
    btn_raw = 3'b100;
    expect_pulse(base + DC + 2, 3'b100);
    for (int k = 0; DC + 2 + RD + k * RR <= 45; k++)
      expect_pulse(base + DC + 2 + RD + k * RR, 3'b100);
    tick(40);
    btn_raw = 3'b000;
    tick(5);
    check("repeat_level_held", int'(btn_level), 4);
    tick(1);
    check("repeat_level_fall", int'(btn_level), 0);
    tick(10);

    // Right released mid-DELAY, then pressed again: timing restarts.
    base    = edge_cnt;
    btn_raw = 3'b010;
    expect_pulse(base + 6, 3'b010);
    tick(6);
    btn_raw = 3'b000;
    tick(16);
    check("redelay_level_off", int'(btn_level), 0);
    base    = edge_cnt;
    btn_raw = 3'b010;
    expect_pulse(base + 6,  3'b010);
    expect_pulse(base + 14, 3'b010);
    expect_pulse(base + 17, 3'b010);
    expect_pulse(base + 20, 3'b010);
    tick(16);
    btn_raw = 3'b000;
    tick(12);
    check("represss_level_off", int'(btn_level), 0);

    // Reset asserted just after a repeat pulse, with left still held.
    base    = edge_cnt;
    btn_raw = 3'b100;
    expect_pulse(base + 6,  3'b100);
    expect_pulse(base + 14, 3'b100);
    expect_pulse(base + 17, 3'b100);
    tick(17);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_pulse", int'(btn_pulse), 0);
    check("rst_async_level", int'(btn_level), 0);
    tick(2);
    rst     = 1'b0;
    base    = edge_cnt;
    expect_pulse(base + 6,  3'b100);
    expect_pulse(base + 14, 3'b100);
    expect_pulse(base + 17, 3'b100);
    expect_pulse(base + 20, 3'b100);
    tick(15);
    btn_raw = 3'b000;
    tick(12);

    // Drop and right together: both pulse bits in the same cycle.
    base    = edge_cnt;
    btn_raw = 3'b011;
    expect_pulse(base + 6, 3'b011);
    tick(6);
    check("simul_level", int'(btn_level), 3);
    btn_raw = 3'b000;
    tick(12);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
